alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID->EX pipeline stage feeding the 64-bit ALU. Captures decoded ops, resolves MEM/WB forwarding,
//  selects A (rs1|PC) and B (rs2|imm), registers them. Valid/ready handshake with a 2-entry skid buffer:
//  full throughput, with a registered in_ready. Outputs drive alu_op/input_alu_A/input_alu_B/is_32bit directly.
// PARAMETERS
//  XLEN       64  datapath width; only 64 is supported
//  REG_IDX_W  5   register index width
// PORTS
//  clk           in   1     rising-edge clock
//  rst_n         in   1     asynchronous active-low reset
//  flush         in   1     kill all held and incoming ops (branch mispredict / trap)
//  in_valid      in   1     upstream beat valid
//  in_ready      out  1     stage can accept (registered)
//  in_pc         in   64    instruction PC
//  in_rs1_idx    in   5     rs1 index
//  in_rs2_idx    in   5     rs2 index
//  in_rs1_data   in   64    regfile rs1 value
//  in_rs2_data   in   64    regfile rs2 value
//  in_imm        in   64    sign-extended immediate
//  in_alu_op     in   4     ALU opcode (cpu_pkg encodings)
//  in_is_32bit   in   1     W-form op
//  in_src_a_pc   in   1     A = PC instead of rs1
//  in_src_b_imm  in   1     B = imm instead of rs2
//  in_rd_idx     in   5     destination index
//  in_rd_we      in   1     destination write enable
//  fwd_mem_we    in   1     MEM-stage result valid for forwarding
//  fwd_mem_rd    in   5     MEM-stage rd
//  fwd_mem_data  in   64    MEM-stage result
//  fwd_wb_we     in   1     WB-stage write enable
//  fwd_wb_rd     in   5     WB-stage rd
//  fwd_wb_data   in   64    WB-stage write data
//  out_valid     out  1     head entry valid
//  out_ready     in   1     EX consumes head
//  alu_op        out  4     to ALU
//  input_alu_A   out  64    to ALU
//  input_alu_B   out  64    to ALU
//  is_32bit      out  1     to ALU
//  out_store_data out 64    forwarded rs2, always (for stores)
//  out_pc        out  64    PC
//  out_rd_idx    out  5     rd
//  out_rd_we     out  1     rd write enable
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, all data outputs 0, state EMPTY.
//  - Transfer on in_valid&in_ready (accept) or out_valid&out_ready (pop). Latency accept->out_valid = 1 cycle.
//  - States: EMPTY (0 held), ONE (head), FULL (head+skid). in_ready = (state!=FULL), registered.
//    EMPTY: accept->ONE. ONE: accept&pop->ONE (head replaced); accept&!pop->FULL; pop&!accept->EMPTY.
//    FULL: pop->ONE (skid moves to head, same cycle; no accept since in_ready=0).
//  - Forwarding is resolved at accept time, per source: MEM match beats WB match beats regfile.
//    A match requires we=1, rd==idx, idx!=0. x0 never forwards and always reads as its regfile value (0).
//  - A = src_a_pc ? pc : fwd(rs1). B = src_b_imm ? imm : fwd(rs2). out_store_data = fwd(rs2) always.
//  - No masking of shift amounts; the ALU uses B[5:0] (B[4:0] for W-forms). No width truncation here.
//  - flush (synchronous, highest priority): next state EMPTY, out_valid=0; any same-cycle accepted beat is
//    dropped, any same-cycle pop still counts downstream. in_ready=1 the cycle after.
//  - Reset mid-operation: immediate return to reset values, all held entries lost.
//  - out_* stable while out_valid&!out_ready (no change until pop or flush).
// CONFIGURATION
//  - FORWARDING_EN defined: MEM/WB bypass as above.
//  - Not defined: fwd_* inputs are ignored (left unconnected), fwd() = regfile data, and the hazard unit stalls instead.
// STRUCTURE
//  - cpu_pkg: ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_SLT=4'b1011, ALU_SLTU=4'b1100, ALU_SLL=4'b1101,
//    ALU_SRL=4'b1110, ALU_SRA=4'b1111; XLEN; REG_IDX_W; skid state enum {EMPTY,ONE,FULL}; op-bundle struct/width.
//  - Sub-module operand_fwd_mux: combinational 3-way priority bypass for one source, instanced for rs1 and rs2.
// TESTING
//  1 Reset then accept ADD rs1=0x5, rs2=0x3, no fwd -> next cycle out_valid=1, A=5, B=3, alu_op=0000.
//  2 fwd_mem rd=7 data=0xAA and fwd_wb rd=7 data=0xBB, rs1_idx=7 -> A=0xAA; with rs1_idx=0 and
//    fwd rd=0 -> A=regfile value 0.
//  3 out_ready=0 while feeding 3 beats -> 2 held, in_ready=0 after the 2nd; raise out_ready -> beats exit
//    in order, no loss, no duplication.
//  4 src_a_pc=1 pc=0x1000, src_b_imm=1 imm=0xFFFF_FFFF_FFFF_FFFC -> A=0x1000, B=-4; out_store_data=fwd(rs2).
//  5 FULL state, then flush together with in_valid -> next cycle out_valid=0, in_ready=1, incoming beat absent.
//  6 Build without FORWARDING_EN and repeat test 2 -> A=in_rs1_data.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encodings, datapath widths,
// skid-buffer state encoding and the operand-stage op bundle.
package cpu_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ALU_OP_W  = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLT  = 4'b1011,
        ALU_SLTU = 4'b1100,
        ALU_SLL  = 4'b1101,
        ALU_SRL  = 4'b1110,
        ALU_SRA  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // One fully resolved ALU operation as held in the head/skid entries.
    typedef struct packed {
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 is_32bit;
        logic [XLEN-1:0]      a;
        logic [XLEN-1:0]      b;
        logic [XLEN-1:0]      store_data;
        logic [XLEN-1:0]      pc;
        logic [REG_IDX_W-1:0] rd_idx;
        logic                 rd_we;
    } op_bundle_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational bypass for one source operand: MEM beats WB beats regfile.
// Register x0 never forwards.
module operand_fwd_mux
    import cpu_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic [XLEN-1:0]      i_rf_data,
    input  logic                 i_mem_we,
    input  logic [REG_IDX_W-1:0] i_mem_rd,
    input  logic [XLEN-1:0]      i_mem_data,
    input  logic                 i_wb_we,
    input  logic [REG_IDX_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]      i_wb_data,
    output logic [XLEN-1:0]      o_data
);

    logic w_idx_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_idx_nz  = (i_idx != '0);
    assign w_mem_hit = i_mem_we && (i_mem_rd == i_idx) && w_idx_nz;
    assign w_wb_hit  = i_wb_we  && (i_wb_rd  == i_idx) && w_idx_nz;

    // Priority select: youngest producer (MEM) wins.
    always_comb begin
        o_data = i_rf_data;
        if (w_mem_hit) begin
            o_data = i_mem_data;
        end else if (w_wb_hit) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID->EX operand stage: forwarding, A/B operand select and a 2-entry
// skid buffer (EMPTY/ONE/FULL) with registered in_ready.
// Build option: define FORWARDING_EN to enable MEM/WB bypassing; otherwise
// the fwd_* inputs are ignored and operands come straight from the regfile.
module alu_operand_stage
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [ALU_OP_W-1:0]  in_alu_op,
    input  logic                 in_is_32bit,
    input  logic                 in_src_a_pc,
    input  logic                 in_src_b_imm,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic                 in_rd_we,
    input  logic                 fwd_mem_we,
    input  logic [REG_IDX_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]      fwd_mem_data,
    input  logic                 fwd_wb_we,
    input  logic [REG_IDX_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]      fwd_wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [XLEN-1:0]      input_alu_A,
    output logic [XLEN-1:0]      input_alu_B,
    output logic                 is_32bit,
    output logic [XLEN-1:0]      out_store_data,
    output logic [XLEN-1:0]      out_pc,
    output logic [REG_IDX_W-1:0] out_rd_idx,
    output logic                 out_rd_we
);

    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    op_bundle_t      w_new;
    op_bundle_t      r_head;
    op_bundle_t      r_skid;
    op_bundle_t      w_head_nxt;
    op_bundle_t      w_skid_nxt;
    skid_state_e     r_state;
    skid_state_e     w_state_nxt;
    logic            r_in_ready;
    logic            w_accept;
    logic            w_pop;

`ifdef FORWARDING_EN
    operand_fwd_mux u_fwd_rs1 (
        .i_idx      (in_rs1_idx),
        .i_rf_data  (in_rs1_data),
        .i_mem_we   (fwd_mem_we),
        .i_mem_rd   (fwd_mem_rd),
        .i_mem_data (fwd_mem_data),
        .i_wb_we    (fwd_wb_we),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_data     (w_rs1_fwd)
    );

    operand_fwd_mux u_fwd_rs2 (
        .i_idx      (in_rs2_idx),
        .i_rf_data  (in_rs2_data),
        .i_mem_we   (fwd_mem_we),
        .i_mem_rd   (fwd_mem_rd),
        .i_mem_data (fwd_mem_data),
        .i_wb_we    (fwd_wb_we),
        .i_wb_rd    (fwd_wb_rd),
        .i_wb_data  (fwd_wb_data),
        .o_data     (w_rs2_fwd)
    );
`else
    // Hazard unit stalls instead of bypassing; indices and fwd_* are unused.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{in_rs1_idx, in_rs2_idx, fwd_mem_we, fwd_mem_rd,
                            fwd_mem_data, fwd_wb_we, fwd_wb_rd, fwd_wb_data};
    assign w_rs1_fwd = in_rs1_data;
    assign w_rs2_fwd = in_rs2_data;
`endif

    // Assemble the incoming op with operand selection resolved now.
    always_comb begin
        w_new            = '0;
        w_new.alu_op     = in_alu_op;
        w_new.is_32bit   = in_is_32bit;
        w_new.a          = in_src_a_pc  ? in_pc  : w_rs1_fwd;
        w_new.b          = in_src_b_imm ? in_imm : w_rs2_fwd;
        w_new.store_data = w_rs2_fwd;
        w_new.pc         = in_pc;
        w_new.rd_idx     = in_rd_idx;
        w_new.rd_we      = in_rd_we;
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = (r_state != EMPTY) && out_ready;

    // Skid-buffer next state and entry updates; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ONE;
                        w_head_nxt  = w_new;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_head_nxt = w_new;
                    end else if (w_accept) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = w_new;
                    end else if (w_pop) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        w_state_nxt = ONE;
                        w_head_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // State, entries and registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_head     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = (r_state != EMPTY);
    assign alu_op         = r_head.alu_op;
    assign input_alu_A    = r_head.a;
    assign input_alu_B    = r_head.b;
    assign is_32bit       = r_head.is_32bit;
    assign out_store_data = r_head.store_data;
    assign out_pc         = r_head.pc;
    assign out_rd_idx     = r_head.rd_idx;
    assign out_rd_we      = r_head.rd_we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
// Expectations follow FORWARDING_EN the same way the design build does.
module tb_alu_operand_stage;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rs2_idx;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic [3:0]  in_alu_op;
    logic        in_is_32bit;
    logic        in_src_a_pc;
    logic        in_src_b_imm;
    logic [4:0]  in_rd_idx;
    logic        in_rd_we;
    logic        fwd_mem_we;
    logic [4:0]  fwd_mem_rd;
    logic [63:0] fwd_mem_data;
    logic        fwd_wb_we;
    logic [4:0]  fwd_wb_rd;
    logic [63:0] fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [63:0] input_alu_A;
    logic [63:0] input_alu_B;
    logic        is_32bit;
    logic [63:0] out_store_data;
    logic [63:0] out_pc;
    logic [4:0]  out_rd_idx;
    logic        out_rd_we;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_v;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_alu_op(in_alu_op), .in_is_32bit(in_is_32bit),
        .in_src_a_pc(in_src_a_pc), .in_src_b_imm(in_src_b_imm),
        .in_rd_idx(in_rd_idx), .in_rd_we(in_rd_we),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .input_alu_A(input_alu_A), .input_alu_B(input_alu_B),
        .is_32bit(is_32bit), .out_store_data(out_store_data), .out_pc(out_pc),
        .out_rd_idx(out_rd_idx), .out_rd_we(out_rd_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] pc, input logic [4:0] rs1i, input logic [63:0] rs1d,
                            input logic [4:0] rs2i, input logic [63:0] rs2d, input logic [3:0] op);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_rs1_idx   = rs1i;
        in_rs1_data  = rs1d;
        in_rs2_idx   = rs2i;
        in_rs2_data  = rs2d;
        in_imm       = 64'h0;
        in_alu_op    = op;
        in_is_32bit  = 1'b0;
        in_src_a_pc  = 1'b0;
        in_src_b_imm = 1'b0;
        in_rd_idx    = 5'd1;
        in_rd_we     = 1'b1;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [63:0] mdata,
                           input logic wwe, input logic [4:0] wrd, input logic [63:0] wdata);
        fwd_mem_we = mwe; fwd_mem_rd = mrd; fwd_mem_data = mdata;
        fwd_wb_we  = wwe; fwd_wb_rd  = wrd; fwd_wb_data  = wdata;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_beat(64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 4'h0);
        in_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if ({input_alu_A, input_alu_B, out_store_data, out_pc} !== 256'h0)
            begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", input_alu_A, input_alu_B, out_store_data, out_pc); end
        total++; if ({alu_op, is_32bit, out_rd_idx, out_rd_we} !== 11'h0)
            begin bad++; $display("FAIL reset_ctrl got=%h exp=0", {alu_op, is_32bit, out_rd_idx, out_rd_we}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set_beat(64'h40, 5'd2, 64'h5, 5'd3, 64'h3, 4'b0000);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (input_alu_A !== 64'h5) begin bad++; $display("FAIL add_A got=%h exp=5", input_alu_A); end
        total++; if (input_alu_B !== 64'h3) begin bad++; $display("FAIL add_B got=%h exp=3", input_alu_B); end
        total++; if (alu_op !== 4'b0000) begin bad++; $display("FAIL add_op got=%b exp=0000", alu_op); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (input_alu_A !== 64'h5 || out_valid !== 1'b1)
            begin bad++; $display("FAIL add_hold got=%h/%b exp=5/1", input_alu_A, out_valid); end
        pop_one();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pop got=%b exp=0", out_valid); end
    endtask

    task automatic test_forwarding();
        // MEM and WB both match rs1=7: MEM wins.
        set_beat(64'h80, 5'd7, 64'h11, 5'd9, 64'h22, 4'b0001);
        set_fwd(1'b1, 5'd7, 64'hAA, 1'b1, 5'd7, 64'hBB);
        tick(); in_valid = 1'b0;
        exp_v = FWD ? 64'hAA : 64'h11;
        total++; if (input_alu_A !== exp_v) begin bad++; $display("FAIL fwd_mem_A got=%h exp=%h", input_alu_A, exp_v); end
        total++; if (input_alu_B !== 64'h22) begin bad++; $display("FAIL fwd_nomatch_B got=%h exp=22", input_alu_B); end
        pop_one();
        // Only WB matches rs1=rs2=9.
        set_beat(64'h84, 5'd9, 64'h11, 5'd9, 64'h22, 4'b0000);
        set_fwd(1'b1, 5'd7, 64'hAA, 1'b1, 5'd9, 64'hBB);
        tick(); in_valid = 1'b0;
        exp_v = FWD ? 64'hBB : 64'h11;
        total++; if (input_alu_A !== exp_v) begin bad++; $display("FAIL fwd_wb_A got=%h exp=%h", input_alu_A, exp_v); end
        exp_v = FWD ? 64'hBB : 64'h22;
        total++; if (out_store_data !== exp_v) begin bad++; $display("FAIL fwd_wb_store got=%h exp=%h", out_store_data, exp_v); end
        pop_one();
        // x0 never forwards.
        set_beat(64'h88, 5'd0, 64'h0, 5'd0, 64'h0, 4'b0000);
        set_fwd(1'b1, 5'd0, 64'hAA, 1'b1, 5'd0, 64'hBB);
        tick(); in_valid = 1'b0;
        total++; if (input_alu_A !== 64'h0) begin bad++; $display("FAIL fwd_x0_A got=%h exp=0", input_alu_A); end
        total++; if (input_alu_B !== 64'h0) begin bad++; $display("FAIL fwd_x0_B got=%h exp=0", input_alu_B); end
        pop_one();
        // MEM rd matches but we=0: WB supplies.
        set_beat(64'h8C, 5'd7, 64'h11, 5'd4, 64'h22, 4'b0000);
        set_fwd(1'b0, 5'd7, 64'hAA, 1'b1, 5'd7, 64'hBB);
        tick(); in_valid = 1'b0;
        exp_v = FWD ? 64'hBB : 64'h11;
        total++; if (input_alu_A !== exp_v) begin bad++; $display("FAIL fwd_memwe0_A got=%h exp=%h", input_alu_A, exp_v); end
        pop_one();
        set_fwd(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_beat(64'h100, 5'd1, 64'hA0, 5'd2, 64'hB0, 4'b0000);
        tick();
        total++; if (out_pc !== 64'h100 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_first got=%h/%b exp=100/1", out_pc, in_ready); end
        set_beat(64'h104, 5'd1, 64'hA1, 5'd2, 64'hB1, 4'b0000);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        set_beat(64'h108, 5'd1, 64'hA2, 5'd2, 64'hB2, 4'b0000);
        tick();
        total++; if (out_pc !== 64'h100 || in_ready !== 1'b0 || input_alu_A !== 64'hA0)
            begin bad++; $display("FAIL bp_hold got=%h/%b/%h exp=100/0/a0", out_pc, in_ready, input_alu_A); end
        out_ready = 1'b1;
        tick();
        total++; if (out_pc !== 64'h104 || input_alu_A !== 64'hA1 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_second got=%h/%h/%b exp=104/a1/1", out_pc, input_alu_A, in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (out_pc !== 64'h108 || input_alu_B !== 64'hB2 || out_valid !== 1'b1)
            begin bad++; $display("FAIL bp_third got=%h/%h/%b exp=108/b2/1", out_pc, input_alu_B, out_valid); end
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_beat(64'h200 + 64'(4 * i), 5'd1, 64'h300 + 64'(i), 5'd2, 64'h0, 4'b1101);
            tick();
            total++; if (out_pc !== 64'h200 + 64'(4 * i) || out_valid !== 1'b1 || in_ready !== 1'b1)
                begin bad++; $display("FAIL b2b_%0d got=%h/%b/%b exp=%h/1/1", i, out_pc, out_valid, in_ready, 64'h200 + 64'(4 * i)); end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_pc_imm();
        set_beat(64'h1000, 5'd5, 64'h55, 5'd3, 64'h77, 4'b0001);
        in_src_a_pc = 1'b1; in_src_b_imm = 1'b1; in_imm = 64'hFFFF_FFFF_FFFF_FFFC;
        in_is_32bit = 1'b1; in_rd_idx = 5'd12;
        set_fwd(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h99);
        tick(); in_valid = 1'b0;
        total++; if (input_alu_A !== 64'h1000) begin bad++; $display("FAIL pcimm_A got=%h exp=1000", input_alu_A); end
        total++; if (input_alu_B !== 64'hFFFF_FFFF_FFFF_FFFC)
            begin bad++; $display("FAIL pcimm_B got=%h exp=fffffffffffffffc", input_alu_B); end
        exp_v = FWD ? 64'h99 : 64'h77;
        total++; if (out_store_data !== exp_v) begin bad++; $display("FAIL pcimm_store got=%h exp=%h", out_store_data, exp_v); end
        total++; if ({alu_op, is_32bit, out_rd_idx, out_rd_we} !== {4'b0001, 1'b1, 5'd12, 1'b1})
            begin bad++; $display("FAIL pcimm_ctrl got=%h exp=%h", {alu_op, is_32bit, out_rd_idx, out_rd_we}, {4'b0001, 1'b1, 5'd12, 1'b1}); end
        pop_one();
        set_fwd(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    endtask

    task automatic test_flush();
        // Flush with an accepted beat in ONE: the beat is dropped.
        set_beat(64'h300, 5'd1, 64'h1, 5'd2, 64'h2, 4'b0000);
        tick();
        set_beat(64'h304, 5'd1, 64'h3, 5'd2, 64'h4, 4'b0000);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_one got=%b/%b exp=0/1", out_valid, in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_one_absent got=%b exp=0", out_valid); end
        // Flush from FULL together with in_valid.
        set_beat(64'h400, 5'd1, 64'h1, 5'd2, 64'h2, 4'b0000);
        tick();
        set_beat(64'h404, 5'd1, 64'h1, 5'd2, 64'h2, 4'b0000);
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_prefull got=%b exp=0", in_ready); end
        set_beat(64'h408, 5'd1, 64'h1, 5'd2, 64'h2, 4'b0000);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL flush_full got=%b/%b exp=0/1", out_valid, in_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_absent got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        set_beat(64'h500, 5'd1, 64'h1234, 5'd2, 64'h2, 4'b0000);
        tick();
        set_beat(64'h504, 5'd1, 64'h5678, 5'd2, 64'h2, 4'b0000);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || input_alu_A !== 64'h0)
            begin bad++; $display("FAIL rstmid got=%b/%b/%h exp=0/1/0", out_valid, in_ready, input_alu_A); end
        #3 rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_lost got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_backpressure();
        test_back_to_back();
        test_pc_imm();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
